// File: rtl/rv32im_decode_pkg.sv
// Shared types and constants for the RV32IM decode stage: opcodes, funct fields,
// ALU/branch operation encodings and the decoded bundle carried through the stage.
package rv32im_decode_pkg;

    localparam int DEC_XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL   = 5'd2,  ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,  ALU_XOR  = 5'd5,  ALU_SRL   = 5'd6,  ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,  ALU_AND  = 5'd9,  ALU_LUI   = 5'd10,
        ALU_MUL  = 5'd16, ALU_MULH = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19,
        ALU_DIV  = 5'd20, ALU_DIVU = 5'd21, ALU_REM   = 5'd22, ALU_REMU = 5'd23
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ = 3'd0, BR_NE = 3'd1, BR_LT = 3'd2, BR_GE = 3'd3,
        BR_LTU = 3'd4, BR_GEU = 3'd5, BR_NONE = 3'd7
    } br_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_SKID = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [DEC_XLEN-1:0] pc;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [31:0]         imm;
        alu_op_e             alu_op;
        br_op_e              br_op;
        logic                rd_we;
        logic                uses_rs1;
        logic                uses_rs2;
        logic                is_mext;
        logic                illegal;
    } decode_bundle_t;

    localparam decode_bundle_t BUNDLE_RESET = '{
        pc: 32'h0, opcode: 7'h0, funct3: 3'h0, rs1: 5'h0, rs2: 5'h0, rd: 5'h0,
        imm: 32'h0, alu_op: ALU_ADD, br_op: BR_NONE, rd_we: 1'b0,
        uses_rs1: 1'b0, uses_rs2: 1'b0, is_mext: 1'b0, illegal: 1'b0
    };

    // Shared by OP and OP-IMM; alt selects SRA over SRL for funct3 101.
    function automatic alu_op_e base_alu_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32im_decode_if.sv
// Upstream (instruction in) and downstream (decoded bundle out) handshake bus of
// the decode stage; signal names are from the stage's point of view.
interface rv32im_decode_if #(
    parameter int XLEN         = 32,
    parameter int ALU_OP_WIDTH = 5,
    parameter int BR_OP_WIDTH  = 3
);
    logic                    i_valid;
    logic                    o_ready;
    logic [31:0]             i_inst;
    logic [XLEN-1:0]         i_pc;
    logic                    o_valid;
    logic                    i_ready;
    logic [XLEN-1:0]         o_pc;
    logic [6:0]              o_opcode;
    logic [2:0]              o_funct3;
    logic [4:0]              o_rs1_addr;
    logic [4:0]              o_rs2_addr;
    logic [4:0]              o_rd_addr;
    logic [XLEN-1:0]         o_imm;
    logic [ALU_OP_WIDTH-1:0] o_alu_op;
    logic [BR_OP_WIDTH-1:0]  o_branch_op;
    logic                    o_rd_we;
    logic                    o_uses_rs1;
    logic                    o_uses_rs2;
    logic                    o_is_mext;
    logic                    o_illegal;

    modport slave (
        input  i_valid, i_inst, i_pc, i_ready,
        output o_ready, o_valid, o_pc, o_opcode, o_funct3, o_rs1_addr, o_rs2_addr,
               o_rd_addr, o_imm, o_alu_op, o_branch_op, o_rd_we, o_uses_rs1,
               o_uses_rs2, o_is_mext, o_illegal
    );

    modport master (
        output i_valid, i_inst, i_pc, i_ready,
        input  o_ready, o_valid, o_pc, o_opcode, o_funct3, o_rs1_addr, o_rs2_addr,
               o_rd_addr, o_imm, o_alu_op, o_branch_op, o_rd_we, o_uses_rs1,
               o_uses_rs2, o_is_mext, o_illegal
    );
endinterface

// File: rtl/rv32im_decode_comb.sv
// Combinational RV32I(+M) instruction decoder producing one decode_bundle_t.
// Define RV32M_EN to decode the M extension; otherwise those encodings are illegal.
module rv32im_decode_comb
    import rv32im_decode_pkg::*;
(
    input  logic [31:0]         i_inst,
    input  logic [DEC_XLEN-1:0] i_pc,
    output decode_bundle_t      o_dec
);
    logic [6:0]  opcode_s;
    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_b_s;
    logic [31:0] imm_u_s;
    logic [31:0] imm_j_s;
    logic        writes_rd_s;

    assign opcode_s = i_inst[6:0];
    assign f3_s     = i_inst[14:12];
    assign f7_s     = i_inst[31:25];
    assign imm_i_s  = {{20{i_inst[31]}}, i_inst[31:20]};
    assign imm_s_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign imm_b_s  = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign imm_u_s  = {i_inst[31:12], 12'h000};
    assign imm_j_s  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    // Field extraction, immediate selection, op mapping and illegal detection.
    always_comb begin
        o_dec        = BUNDLE_RESET;
        o_dec.pc     = i_pc;
        o_dec.opcode = opcode_s;
        o_dec.funct3 = f3_s;
        o_dec.rs1    = i_inst[19:15];
        o_dec.rs2    = i_inst[24:20];
        o_dec.rd     = i_inst[11:7];
        writes_rd_s  = 1'b0;
        case (opcode_s)
            OPC_LUI, OPC_AUIPC: begin
                o_dec.imm    = imm_u_s;
                o_dec.alu_op = ALU_LUI;
                writes_rd_s  = 1'b1;
            end
            OPC_JAL: begin
                o_dec.imm   = imm_j_s;
                writes_rd_s = 1'b1;
            end
            OPC_JALR: begin
                o_dec.imm      = imm_i_s;
                o_dec.uses_rs1 = 1'b1;
                o_dec.illegal  = (f3_s != 3'b000);
                writes_rd_s    = 1'b1;
            end
            OPC_BRANCH: begin
                o_dec.imm      = imm_b_s;
                o_dec.uses_rs1 = 1'b1;
                o_dec.uses_rs2 = 1'b1;
                case (f3_s)
                    3'b000:  o_dec.br_op = BR_EQ;
                    3'b001:  o_dec.br_op = BR_NE;
                    3'b100:  o_dec.br_op = BR_LT;
                    3'b101:  o_dec.br_op = BR_GE;
                    3'b110:  o_dec.br_op = BR_LTU;
                    3'b111:  o_dec.br_op = BR_GEU;
                    default: o_dec.illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                o_dec.imm      = imm_i_s;
                o_dec.uses_rs1 = 1'b1;
                o_dec.illegal  = (f3_s == 3'b011) || (f3_s == 3'b110) || (f3_s == 3'b111);
                writes_rd_s    = 1'b1;
            end
            OPC_STORE: begin
                o_dec.imm      = imm_s_s;
                o_dec.uses_rs1 = 1'b1;
                o_dec.uses_rs2 = 1'b1;
                o_dec.illegal  = (f3_s > 3'b010);
            end
            OPC_OP_IMM: begin
                o_dec.imm      = imm_i_s;
                o_dec.uses_rs1 = 1'b1;
                o_dec.alu_op   = base_alu_op(f3_s, i_inst[30]);
                writes_rd_s    = 1'b1;
                if (f3_s == F3_SLL) begin
                    o_dec.illegal = (f7_s != F7_BASE);
                end else if (f3_s == F3_SR) begin
                    o_dec.illegal = (f7_s != F7_BASE) && (f7_s != F7_ALT);
                end else begin
                    o_dec.illegal = 1'b0;
                end
            end
            OPC_OP: begin
                o_dec.uses_rs1 = 1'b1;
                o_dec.uses_rs2 = 1'b1;
                writes_rd_s    = 1'b1;
                case (f7_s)
                    F7_BASE: o_dec.alu_op = base_alu_op(f3_s, 1'b0);
                    F7_ALT: begin
                        if (f3_s == F3_ADD_SUB) begin
                            o_dec.alu_op = ALU_SUB;
                        end else if (f3_s == F3_SR) begin
                            o_dec.alu_op = ALU_SRA;
                        end else begin
                            o_dec.illegal = 1'b1;
                        end
                    end
                    F7_MEXT: begin
`ifdef RV32M_EN
                        o_dec.alu_op  = alu_op_e'({2'b10, f3_s});
                        o_dec.is_mext = 1'b1;
`else
                        o_dec.illegal = 1'b1;
`endif
                    end
                    default: o_dec.illegal = 1'b1;
                endcase
            end
            default: o_dec.illegal = 1'b1;
        endcase
        o_dec.illegal = o_dec.illegal | (i_inst[1:0] != 2'b11);
        o_dec.rd_we   = writes_rd_s && !o_dec.illegal && (o_dec.rd != 5'd0);
    end
endmodule

// File: rtl/rv32im_decode_stage.sv
// Registered RV32IM decode stage: decoder + output register + one-entry skid buffer,
// strict FIFO under back-pressure, flush kills everything held. Honours RV32M_EN.
module rv32im_decode_stage
    import rv32im_decode_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int ALU_OP_WIDTH = 5,
    parameter int BR_OP_WIDTH  = 3
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_flush,
    rv32im_decode_if.slave dec_if
);
    stage_state_e   state_q, state_d;
    decode_bundle_t out_q, out_d;
    decode_bundle_t skid_q, skid_d;
    decode_bundle_t dec_new;
    logic           accept_s;
    logic           drain_s;
    logic           ready_s;
    logic           valid_s;

    rv32im_decode_comb u_decode (
        .i_inst (dec_if.i_inst),
        .i_pc   (DEC_XLEN'(dec_if.i_pc)),
        .o_dec  (dec_new)
    );

    assign ready_s  = (state_q != ST_SKID);
    assign valid_s  = (state_q != ST_EMPTY);
    assign accept_s = dec_if.i_valid && ready_s && !i_flush;
    assign drain_s  = valid_s && dec_if.i_ready;

    // Next state and register loads; flush overrides any transfer this cycle.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d = ST_FULL;
                        out_d   = dec_new;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (accept_s && drain_s) begin
                        out_d = dec_new;
                    end else if (accept_s) begin
                        state_d = ST_SKID;
                        skid_d  = dec_new;
                    end else if (drain_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (drain_s) begin
                        state_d = ST_FULL;
                        out_d   = skid_q;
                    end else begin
                        state_d = ST_SKID;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State, output register and skid register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= BUNDLE_RESET;
            skid_q  <= BUNDLE_RESET;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign dec_if.o_ready     = ready_s;
    assign dec_if.o_valid     = valid_s;
    assign dec_if.o_pc        = XLEN'(out_q.pc);
    assign dec_if.o_opcode    = out_q.opcode;
    assign dec_if.o_funct3    = out_q.funct3;
    assign dec_if.o_rs1_addr  = out_q.rs1;
    assign dec_if.o_rs2_addr  = out_q.rs2;
    assign dec_if.o_rd_addr   = out_q.rd;
    assign dec_if.o_imm       = XLEN'($signed(out_q.imm));
    assign dec_if.o_alu_op    = ALU_OP_WIDTH'(out_q.alu_op);
    assign dec_if.o_branch_op = BR_OP_WIDTH'(out_q.br_op);
    assign dec_if.o_rd_we     = out_q.rd_we;
    assign dec_if.o_uses_rs1  = out_q.uses_rs1;
    assign dec_if.o_uses_rs2  = out_q.uses_rs2;
    assign dec_if.o_is_mext   = out_q.is_mext;
    assign dec_if.o_illegal   = out_q.illegal;
endmodule

// File: tb/tb_rv32im_decode_stage.sv
// Self-checking bench for rv32im_decode_stage: directed steps then random traffic,
// checked against an arithmetic decode model and a two-deep FIFO occupancy model.
module tb_rv32im_decode_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        int          alu;
        int          br;
        logic        rd_we;
        logic        u1;
        logic        u2;
        logic        mext;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    rv32im_decode_if #(.XLEN(32), .ALU_OP_WIDTH(5), .BR_OP_WIDTH(3)) bus ();

    rv32im_decode_stage #(.XLEN(32), .ALU_OP_WIDTH(5), .BR_OP_WIDTH(3)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .dec_if  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference decode from the instruction-set rules, immediates by integer arithmetic.
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        int s = $signed(inst);
        int f3 = int'(inst[14:12]);
        int f7 = int'(inst[31:25]);
        int base_alu[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int br_map[8] = '{0, 1, -1, -1, 2, 3, 4, 5};
        int imm_i = s >>> 20;
        int imm_s = (s >>> 25) * 32 + int'(inst[11:7]);
        int imm_b = (s >>> 31) * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
        int imm_j = (s >>> 31) * 1048576 + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
        bit wr = 1'b0;
        e.pc = pc; e.opcode = inst[6:0]; e.funct3 = inst[14:12];
        e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7];
        e.imm = 32'h0; e.alu = 0; e.br = 7; e.u1 = 1'b0; e.u2 = 1'b0; e.mext = 1'b0; e.ill = 1'b0;
        case (inst[6:0])
            7'h37, 7'h17: begin e.imm = inst & 32'hFFFFF000; e.alu = 10; wr = 1'b1; end
            7'h6F: begin e.imm = imm_j; wr = 1'b1; end
            7'h67: begin e.imm = imm_i; e.u1 = 1'b1; wr = 1'b1; e.ill = (f3 != 0); end
            7'h63: begin
                e.imm = imm_b; e.u1 = 1'b1; e.u2 = 1'b1;
                if (br_map[f3] < 0) e.ill = 1'b1; else e.br = br_map[f3];
            end
            7'h03: begin e.imm = imm_i; e.u1 = 1'b1; wr = 1'b1; e.ill = (f3 == 3 || f3 == 6 || f3 == 7); end
            7'h23: begin e.imm = imm_s; e.u1 = 1'b1; e.u2 = 1'b1; e.ill = (f3 > 2); end
            7'h13: begin
                e.imm = imm_i; e.u1 = 1'b1; wr = 1'b1;
                e.alu = (f3 == 5 && inst[30]) ? 7 : base_alu[f3];
                if (f3 == 1) e.ill = (f7 != 0);
                if (f3 == 5) e.ill = !(f7 == 0 || f7 == 32);
            end
            7'h33: begin
                e.u1 = 1'b1; e.u2 = 1'b1; wr = 1'b1;
                if (f7 == 0) e.alu = base_alu[f3];
                else if (f7 == 32 && f3 == 0) e.alu = 1;
                else if (f7 == 32 && f3 == 5) e.alu = 7;
`ifdef RV32M_EN
                else if (f7 == 1) begin e.alu = 16 + f3; e.mext = 1'b1; end
`endif
                else e.ill = 1'b1;
            end
            default: e.ill = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) e.ill = 1'b1;
        e.rd_we = wr && !e.ill && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops[9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        logic [6:0] f7s[3] = '{7'h00, 7'h20, 7'h01};
        logic [31:0] r = $urandom;
        int k = $urandom_range(0, 9);
        if (k < 9) begin
            r[6:0] = ops[k];
            if ((k >= 7) && ($urandom_range(0, 3) != 0)) r[31:25] = f7s[$urandom_range(0, 2)];
        end
        return r;
    endfunction

    // One clock: check outputs against the model queue, drive inputs, advance the model.
    task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rdy, input logic fl);
        exp_t e;
        bit   exp_ready = (q.size() < 2);
        bit   exp_valid = (q.size() > 0);
        chk("o_valid", bus.o_valid, exp_valid);
        chk("o_ready", bus.o_ready, exp_ready);
        if (exp_valid) begin
            e = q[0];
            chk("pc", bus.o_pc, e.pc);
            chk("opcode", bus.o_opcode, e.opcode);
            chk("funct3", bus.o_funct3, e.funct3);
            chk("rs1", bus.o_rs1_addr, e.rs1);
            chk("rs2", bus.o_rs2_addr, e.rs2);
            chk("rd", bus.o_rd_addr, e.rd);
            chk("imm", bus.o_imm, e.imm);
            chk("rd_we", bus.o_rd_we, e.rd_we);
            chk("uses_rs1", bus.o_uses_rs1, e.u1);
            chk("uses_rs2", bus.o_uses_rs2, e.u2);
            chk("is_mext", bus.o_is_mext, e.mext);
            chk("illegal", bus.o_illegal, e.ill);
            if (!e.ill) begin
                chk("alu_op", bus.o_alu_op, e.alu[4:0]);
                chk("branch_op", bus.o_branch_op, e.br[2:0]);
            end
        end
        bus.i_valid = v; bus.i_inst = inst; bus.i_pc = pc; bus.i_ready = rdy; flush = fl;
        if (fl) begin
            q.delete();
        end else begin
            if (exp_valid && rdy) void'(q.pop_front());
            if (v && exp_ready) q.push_back(model(inst, pc));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.i_valid = 1'b0; bus.i_inst = 32'h0; bus.i_pc = 32'h0; bus.i_ready = 1'b0;
        @(negedge clk);
        chk("rst_valid", bus.o_valid, 1'b0);
        chk("rst_ready", bus.o_ready, 1'b1);
        chk("rst_alu", bus.o_alu_op, 5'd0);
        chk("rst_br", bus.o_branch_op, 3'd7);
        chk("rst_imm", bus.o_imm, 32'h0);
        chk("rst_pc", bus.o_pc, 32'h0);
        rst_n = 1'b1;

        cyc(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
        chk("addi_imm", bus.o_imm, 32'd5);
        chk("addi_alu", bus.o_alu_op, 5'd0);
        chk("addi_rd", bus.o_rd_addr, 5'd1);
        chk("addi_we", bus.o_rd_we, 1'b1);
        chk("addi_rs2", bus.o_uses_rs2, 1'b0);
        cyc(1'b1, 32'h402081B3, 32'h104, 1'b1, 1'b0);
        chk("sub_alu", bus.o_alu_op, 5'd1);
        cyc(1'b1, 32'h4032D293, 32'h108, 1'b1, 1'b0);
        chk("srai_alu", bus.o_alu_op, 5'd7);
        chk("srai_shamt", bus.o_imm & 32'h1F, 32'd3);
        cyc(1'b1, 32'h40000093, 32'h10C, 1'b1, 1'b0);
        chk("addi30_alu", bus.o_alu_op, 5'd0);
        cyc(1'b1, 32'h02208333, 32'h110, 1'b1, 1'b0);
`ifdef RV32M_EN
        chk("mul_alu", bus.o_alu_op, 5'd16);
        chk("mul_mext", bus.o_is_mext, 1'b1);
`else
        chk("mul_ill", bus.o_illegal, 1'b1);
        chk("mul_we", bus.o_rd_we, 1'b0);
        chk("mul_alu", bus.o_alu_op, 5'd0);
        chk("mul_mext", bus.o_is_mext, 1'b0);
`endif
        cyc(1'b1, 32'h0020A063, 32'h114, 1'b1, 1'b0);
        chk("br010_ill", bus.o_illegal, 1'b1);
        cyc(1'b1, 32'hFFFFFFFF, 32'h118, 1'b1, 1'b0);
        chk("ones_ill", bus.o_illegal, 1'b1);
        cyc(1'b1, 32'h00208463, 32'h11C, 1'b1, 1'b0);
        chk("beq_br", bus.o_branch_op, 3'd0);
        chk("beq_imm", bus.o_imm, 32'd8);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Back-pressure: A held, B in skid, C refused then re-presented.
        cyc(1'b1, 32'h00100113, 32'h200, 1'b0, 1'b0);
        cyc(1'b1, 32'h00200193, 32'h204, 1'b0, 1'b0);
        chk("skid_ready", bus.o_ready, 1'b0);
        chk("skid_hold_pc", bus.o_pc, 32'h200);
        cyc(1'b1, 32'h00300213, 32'h208, 1'b0, 1'b0);
        cyc(1'b1, 32'h00300213, 32'h208, 1'b1, 1'b0);
        cyc(1'b1, 32'h00300213, 32'h208, 1'b1, 1'b0);
        chk("c_pc", bus.o_pc, 32'h208);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while in SKID with a valid offer.
        cyc(1'b1, 32'h00100113, 32'h300, 1'b0, 1'b0);
        cyc(1'b1, 32'h00200193, 32'h304, 1'b0, 1'b0);
        cyc(1'b1, 32'h00300213, 32'h308, 1'b0, 1'b1);
        chk("flush_valid", bus.o_valid, 1'b0);
        chk("flush_ready", bus.o_ready, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream.
        cyc(1'b1, 32'h00100113, 32'h400, 1'b0, 1'b0);
        cyc(1'b1, 32'h00200193, 32'h404, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.o_valid, 1'b0);
        chk("arst_ready", bus.o_ready, 1'b1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFF_FFFC,
                $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
